// File: rtl/carry_skip_subtractor_seq.sv
// Multi-cycle block-serial subtractor: diff = a - b - bin, one BLK_W-bit block per cycle.
// Define CSS_OVF_EN to add the signed-overflow output ovf.
module carry_skip_subtractor_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CSS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NBLK = WIDTH / BLK_W;
    localparam int unsigned K_W  = (NBLK > 1) ? $clog2(NBLK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [K_W-1:0]   k;
    logic             carry;

    logic             accept;
    logic             last_blk;
    logic [31:0]      blk_off;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] nb_sh;
    logic [BLK_W-1:0] blk_a;
    logic [BLK_W-1:0] blk_nb;
    logic [BLK_W-1:0] blk_p;
    logic [BLK_W:0]   blk_sum;
    logic [BLK_W-1:0] blk_d;
    logic             carry_nxt;
    logic [WIDTH-1:0] blk_mask;
    logic [WIDTH-1:0] diff_nxt;

    assign accept   = in_valid && in_ready;
    assign last_blk = (k == K_W'(NBLK - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last_blk) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One block of a + ~b + c; a fully-propagating block passes the incoming carry straight through
    always_comb begin
        blk_off   = 32'(k) * 32'(BLK_W);
        a_sh      = a_r >> blk_off;
        nb_sh     = (~b_r) >> blk_off;
        blk_a     = a_sh[BLK_W-1:0];
        blk_nb    = nb_sh[BLK_W-1:0];
        blk_p     = blk_a ^ blk_nb;
        blk_sum   = {1'b0, blk_a} + {1'b0, blk_nb} + (BLK_W+1)'(carry);
        blk_d     = blk_sum[BLK_W-1:0];
        carry_nxt = (&blk_p) ? carry : blk_sum[BLK_W];
        blk_mask  = WIDTH'({BLK_W{1'b1}}) << blk_off;
        diff_nxt  = (diff & ~blk_mask) | (WIDTH'(blk_d) << blk_off);
    end

    // Operand latch, block walk and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            k         <= '0;
            carry     <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef CSS_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= ~bin;
                        k     <= '0;
                    end
                end
                S_RUN: begin
                    diff  <= diff_nxt;
                    carry <= carry_nxt;
                    k     <= k + K_W'(1);
                    if (last_blk) begin
                        bout <= ~carry_nxt;
`ifdef CSS_OVF_EN
                        ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                (blk_d[BLK_W-1] != a_r[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carry_skip_subtractor_seq.sv
// Scoreboard bench for carry_skip_subtractor_seq: directed corner cases, back-pressure and mid-op reset.
module tb_carry_skip_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
`ifdef CSS_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    carry_skip_subtractor_seq #(.WIDTH(32), .BLK_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CSS_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
        exp_t        e;
        logic [32:0] t;
        t      = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        e.diff = t[31:0];
        e.bout = t[32];
        e.ovf  = (ma[31] != mb[31]) && (t[31] != ma[31]);
        return e;
    endfunction

    // Present an operation, push its expectation, then scramble the inputs after acceptance
    task automatic send_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbin);
        int cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        sb.push_back(model(ta, tb, tbin));
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
    endtask

    task automatic wait_result(input int exp_lat);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || (exp_lat >= 0 && lat != exp_lat)) begin
            errors++;
            $display("FAIL latency: out_valid=%b after %0d cycles, required 1 after %0d", out_valid, lat, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: result present but queue empty");
            e.diff = 'x; e.bout = 1'bx; e.ovf = 1'bx;
        end else begin
            e = sb.pop_front();
        end
        checks++;
        if (diff !== e.diff) begin
            errors++;
            $display("FAIL diff: got %h required %h", diff, e.diff);
        end
        checks++;
        if (bout !== e.bout) begin
            errors++;
            $display("FAIL bout: got %b required %b", bout, e.bout);
        end
`ifdef CSS_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf: got %b required %b", ovf, e.ovf);
        end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b required 1/0/0/0",
                     in_ready, out_valid, diff, bout);
        end
`ifdef CSS_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b required 0", ovf);
        end
`endif
    endtask

    task automatic test_directed();
        send_op(32'h0000_0000, 32'h0000_0000, 1'b0); wait_result(4);
        send_op(32'h0001_0000, 32'h0000_0001, 1'b0); wait_result(4);
        send_op(32'h0000_0000, 32'h0000_0001, 1'b0); wait_result(4);
        send_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_result(4);
        send_op(32'h8000_0000, 32'h0000_0001, 1'b0); wait_result(4);
        send_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_result(4);
        send_op(32'h0000_0000, 32'h0000_0000, 1'b1); wait_result(4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            send_op($urandom, $urandom, 1'($urandom));
            wait_result(4);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1;
        int   cnt = 0;
        send_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        e1 = sb[0];
        a = 32'hA5A5_0000; b = 32'h0000_5A5A; bin = 1'b0; in_valid = 1'b1;
        sb.push_back(model(a, b, bin));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e1.diff || bout !== e1.bout) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b diff=%h bout=%b required 1/0/%h/%b",
                         i, out_valid, in_ready, diff, bout, e1.diff, e1.bout);
            end
        end
        wait_result(0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_accept: in_ready=%b required 0", in_ready);
        end
        wait_result(4);
    endtask

    task automatic test_reset_mid_op();
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%h required 1/0/00000000",
                     in_ready, out_valid, diff);
        end
        repeat (6) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abandoned: out_valid=%b required 0", out_valid);
            end
        end
        send_op(32'h0000_0100, 32'h0000_0001, 1'b1);
        wait_result(4);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
